branch_predict_unit: RTL

Parametrised successor to the single-cycle jump/branch resolver: resolves branches and jumps in EX and adds a dynamic predictor, a 2-bit-counter BHT plus tagged BTB. IF uses it for a combinational next-PC guess. EX resolution of each prediction produces a redirect and flush only on a mispredict, not on every taken branch. Sits between the PC mux (IF) and the ALU flag outputs (EX).

---
 rtl/bpu_pkg.sv | 45 ++++
 rtl/branch_target_buffer.sv | 62 ++++++
 rtl/branch_predict_unit.sv | 137 +++++++++++++
 3 files changed

// File: rtl/bpu_pkg.sv
// bpu_pkg: shared definitions for the branch prediction unit.
//   - branch condition (func3) encodings
//   - 2-bit saturating counter encodings and their update function
//   - BTB entry layout (valid, jump, tag, target)
package bpu_pkg;

    localparam logic [2:0] BEQ  = 3'b000;
    localparam logic [2:0] BNE  = 3'b001;
    localparam logic [2:0] BLT  = 3'b100;
    localparam logic [2:0] BGE  = 3'b101;
    localparam logic [2:0] BLTU = 3'b110;
    localparam logic [2:0] BGEU = 3'b111;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } bht_cnt_e;

    // Tag and target fields are sized for the widest supported address;
    // narrower configurations zero-extend into them.
    localparam int BTB_FIELD_W = 64;

    typedef struct packed {
        logic                   valid;
        logic                   jump;
        logic [BTB_FIELD_W-1:0] tag;
        logic [BTB_FIELD_W-1:0] target;
    } btb_entry_t;

    // Saturating step toward taken or not-taken; ST and SNT hold.
    function automatic bht_cnt_e cnt_update(input bht_cnt_e cnt, input logic taken);
        bht_cnt_e next;
        next = cnt;
        case (cnt)
            SNT:     next = taken ? WNT : SNT;
            WNT:     next = taken ? WT  : SNT;
            WT:      next = taken ? ST  : WNT;
            default: next = taken ? ST  : WT;
        endcase
        return next;
    endfunction

endpackage

// File: rtl/branch_target_buffer.sv
// branch_target_buffer: direct-mapped, tagged target store.
// Ports:
//   clk, reset_n          clock and active-low async reset (clears all valid bits)
//   rd_pc                 lookup address (IF)
//   rd_hit/rd_jump        entry valid with matching tag / entry holds a jump
//   rd_target             stored target on hit, zero on miss
//   wr_en, wr_pc          write request and address (EX resolution)
//   wr_jump, wr_target    fields written into the entry
module branch_target_buffer
    import bpu_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int ENTRIES = 64
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [XLEN-1:0] rd_pc,
    output logic            rd_hit,
    output logic            rd_jump,
    output logic [XLEN-1:0] rd_target,
    input  logic            wr_en,
    input  logic [XLEN-1:0] wr_pc,
    input  logic            wr_jump,
    input  logic [XLEN-1:0] wr_target
);

    localparam int IDX   = $clog2(ENTRIES);
    localparam int TAG_W = XLEN - IDX - 2;

    btb_entry_t entries_q [ENTRIES];

    logic [IDX-1:0]   rd_idx;
    logic [IDX-1:0]   wr_idx;
    logic [TAG_W-1:0] rd_tag;
    logic [TAG_W-1:0] wr_tag;

    assign rd_idx = rd_pc[IDX+1:2];
    assign rd_tag = rd_pc[XLEN-1:IDX+2];
    assign wr_idx = wr_pc[IDX+1:2];
    assign wr_tag = wr_pc[XLEN-1:IDX+2];

    // Reads see the registered array only, so a same-cycle write to the
    // looked-up index is not visible until the following cycle.
    assign rd_hit    = entries_q[rd_idx].valid &&
                       (entries_q[rd_idx].tag == BTB_FIELD_W'(rd_tag));
    assign rd_jump   = entries_q[rd_idx].jump;
    assign rd_target = rd_hit ? entries_q[rd_idx].target[XLEN-1:0] : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                entries_q[i] <= '0;
            end
        end else if (wr_en) begin
            entries_q[wr_idx] <= '{valid:  1'b1,
                                   jump:   wr_jump,
                                   tag:    BTB_FIELD_W'(wr_tag),
                                   target: BTB_FIELD_W'(wr_target)};
        end
    end

endmodule

// File: rtl/branch_predict_unit.sv
// branch_predict_unit: EX-stage branch/jump resolver with a dynamic
// predictor (untagged 2-bit BHT plus tagged BTB) for IF next-PC guessing.
// Ports:
//   clk, reset_n                  clock; async active-low reset, released synchronously
//   fetch_pc -> pred_taken/target IF lookup, combinational
//   ex_*, eq/lt/ltu_flag          instruction being resolved in EX and ALU flags
//   ex_pred_taken/target          prediction that travelled with the EX instruction
//   pc_mux_control, reg_flush     redirect fetch and flush on a mispredict
//   redirect_addr                 corrected PC
//   mispredict_count              saturating mispredict counter
module branch_predict_unit
    import bpu_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int ENTRIES = 64,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [XLEN-1:0]  fetch_pc,
    output logic             pred_taken,
    output logic [XLEN-1:0]  pred_target,
    input  logic             ex_valid,
    input  logic             ex_stall,
    input  logic [XLEN-1:0]  ex_pc,
    input  logic             ex_branch,
    input  logic             ex_jump,
    input  logic [2:0]       ex_func3,
    input  logic             eq_flag,
    input  logic             lt_flag,
    input  logic             ltu_flag,
    input  logic [XLEN-1:0]  ex_target,
    input  logic             ex_pred_taken,
    input  logic [XLEN-1:0]  ex_pred_target,
    output logic             pc_mux_control,
    output logic [XLEN-1:0]  redirect_addr,
    output logic             reg_flush,
    output logic [CNT_W-1:0] mispredict_count
);

    localparam int IDX = $clog2(ENTRIES);

    // Reset asserts immediately but releases only after two clean clock
    // edges; rst_ok is the internal reset for every table and counter.
    logic [1:0] rst_sync_q;
    logic       rst_ok;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_ok = rst_sync_q[1];

    logic            cond;
    logic            actual;
    logic            resolve;
    logic            mispredict;
    logic [XLEN-1:0] fall_through;
    logic [IDX-1:0]  fetch_idx;
    logic [IDX-1:0]  ex_idx;
    logic            btb_hit;
    logic            btb_jump;
    logic [XLEN-1:0] btb_target;
    bht_cnt_e        bht_q [ENTRIES];
    logic [CNT_W-1:0] count_q;

    always_comb begin
        cond = 1'b0;
        case (ex_func3)
            BEQ:     cond = eq_flag;
            BNE:     cond = ~eq_flag;
            BLT:     cond = lt_flag;
            BGE:     cond = ~lt_flag;
            BLTU:    cond = ltu_flag;
            BGEU:    cond = ~ltu_flag;
            default: cond = 1'b0;
        endcase
    end

    assign actual       = ex_jump | (ex_branch & cond);
    // A stalled instruction stays in EX, so it resolves once the stall lifts.
    assign resolve      = rst_ok & ex_valid & (ex_branch | ex_jump) & ~ex_stall;
    assign mispredict   = resolve & ((actual != ex_pred_taken) |
                                     (actual & (ex_pred_target != ex_target)));
    assign fall_through = ex_pc + XLEN'(4);

    assign pc_mux_control   = mispredict;
    assign reg_flush        = mispredict;
    assign redirect_addr    = (mispredict & actual) ? ex_target : fall_through;
    assign mispredict_count = count_q;

    assign fetch_idx = fetch_pc[IDX+1:2];
    assign ex_idx    = ex_pc[IDX+1:2];

    branch_target_buffer #(
        .XLEN    (XLEN),
        .ENTRIES (ENTRIES)
    ) u_btb (
        .clk       (clk),
        .reset_n   (rst_ok),
        .rd_pc     (fetch_pc),
        .rd_hit    (btb_hit),
        .rd_jump   (btb_jump),
        .rd_target (btb_target),
        .wr_en     (resolve & actual),
        .wr_pc     (ex_pc),
        .wr_jump   (ex_jump),
        .wr_target (ex_target)
    );

    // Jumps in the BTB always predict taken; branches follow the counter MSB.
    assign pred_taken  = btb_hit & (btb_jump | bht_q[fetch_idx][1]);
    assign pred_target = btb_target;

    always_ff @(posedge clk or negedge rst_ok) begin
        if (!rst_ok) begin
            for (int i = 0; i < ENTRIES; i++) begin
                bht_q[i] <= WNT;
            end
        end else if (resolve) begin
            bht_q[ex_idx] <= cnt_update(bht_q[ex_idx], actual);
        end
    end

    always_ff @(posedge clk or negedge rst_ok) begin
        if (!rst_ok) begin
            count_q <= '0;
        end else if (mispredict && (count_q != '1)) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

endmodule
